// File: rtl/pc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: state codes,
// opcode/funct values, datapath mux selects and exception vectors.
package mips_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_RST      = 4'd0;
  localparam state_t ST_FETCH    = 4'd1;
  localparam state_t ST_DEC      = 4'd2;
  localparam state_t ST_EXR      = 4'd3;
  localparam state_t ST_WBR      = 4'd4;
  localparam state_t ST_EXI      = 4'd5;
  localparam state_t ST_WBI      = 4'd6;
  localparam state_t ST_BRAN     = 4'd7;
  localparam state_t ST_JMP      = 4'd8;
  localparam state_t ST_JR       = 4'd9;
  localparam state_t ST_RTE      = 4'd10;
  localparam state_t ST_EXC_SAVE = 4'd11;
  localparam state_t ST_EXC_VEC  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_RTE = 6'h13;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EPC    = 2'b11;

  localparam logic [1:0] ASA_PC   = 2'b00;
  localparam logic [1:0] ASA_A    = 2'b01;
  localparam logic [1:0] ASA_ZERO = 2'b10;

  localparam logic [2:0] ASB_B       = 3'b000;
  localparam logic [2:0] ASB_FOUR    = 3'b001;
  localparam logic [2:0] ASB_IMM     = 3'b010;
  localparam logic [2:0] ASB_IMM_SL2 = 3'b011;
  localparam logic [2:0] ASB_VEC     = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [31:0] OPC_VEC_DEF = 32'h0000_0080;
  localparam logic [31:0] OVF_VEC_DEF = 32'h0000_0084;

  function automatic logic is_rtype_alu(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  // and shares the EXR path but can never trap on overflow
  function automatic logic funct_can_overflow(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/pc_ctrl_fsm_if.sv
// Control bus between the sequencer (master) and the datapath (slave):
// instruction fields and ALU flags in, strobes and mux selects out.
interface pc_ctrl_fsm_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        overflow;
  logic [1:0]  pc_src;
  logic        pc_write;
  logic        iord;
  logic        ir_write;
  logic [1:0]  alu_src_a;
  logic [2:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_dst;
  logic        reg_write;
  logic        epc_write;
  logic [31:0] exc_vector;
  logic        cause;
  logic [3:0]  state_dbg;

  modport master (
    input  opcode, funct, zero, overflow,
    output pc_src, pc_write, iord, ir_write, alu_src_a, alu_src_b, alu_op,
           reg_dst, reg_write, epc_write, exc_vector, cause, state_dbg
  );

  modport slave (
    output opcode, funct, zero, overflow,
    input  pc_src, pc_write, iord, ir_write, alu_src_a, alu_src_b, alu_op,
           reg_dst, reg_write, epc_write, exc_vector, cause, state_dbg
  );
endinterface

// File: rtl/pc_ctrl_fsm.sv
// Multicycle MIPS control sequencer: sole driver of PC source/write and of the
// datapath strobes for fetch, decode, execute, branch/jump and exceptions.
module pc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] OPC_VEC = OPC_VEC_DEF,
  parameter logic [31:0] OVF_VEC = OVF_VEC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pc_ctrl_fsm_if.master bus
);

  state_t state;
  state_t next_state;
  logic   cause_q;
  logic   next_cause;
  logic   cause_valid;

  always_comb begin
    next_state = state;
    next_cause = cause_q;
    case (state)
      ST_RST:   next_state = ST_FETCH;
      ST_FETCH: next_state = ST_DEC;
      ST_DEC: begin
        next_state = ST_EXC_SAVE;
        next_cause = 1'b0;
        case (bus.opcode)
          OP_RTYPE: begin
            if (is_rtype_alu(bus.funct))   next_state = ST_EXR;
            else if (bus.funct == FN_JR)   next_state = ST_JR;
            else if (bus.funct == FN_RTE)  next_state = ST_RTE;
          end
          OP_ADDI:        next_state = ST_EXI;
          OP_BEQ, OP_BNE: next_state = ST_BRAN;
          OP_J:           next_state = ST_JMP;
          default:        ;
        endcase
      end
      ST_EXR: begin
        if (bus.overflow && funct_can_overflow(bus.funct)) begin
          next_state = ST_EXC_SAVE;
          next_cause = 1'b1;
        end else begin
          next_state = ST_WBR;
        end
      end
      ST_EXI: begin
        if (bus.overflow) begin
          next_state = ST_EXC_SAVE;
          next_cause = 1'b1;
        end else begin
          next_state = ST_WBI;
        end
      end
      ST_WBR, ST_WBI, ST_BRAN, ST_JMP, ST_JR, ST_RTE, ST_EXC_VEC:
        next_state = ST_FETCH;
      ST_EXC_SAVE: next_state = ST_EXC_VEC;
      default:     next_state = ST_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RST;
      cause_q     <= 1'b0;
      cause_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == ST_EXC_SAVE) begin
        cause_q     <= next_cause;
        cause_valid <= 1'b1;
      end else if (next_state == ST_FETCH) begin
        cause_valid <= 1'b0;
      end
    end
  end

  // Moore decode; only the BRAN pc_write looks at an input (zero)
  always_comb begin
    bus.pc_src    = PCS_ALU;
    bus.pc_write  = 1'b0;
    bus.iord      = 1'b0;
    bus.ir_write  = 1'b0;
    bus.alu_src_a = ASA_PC;
    bus.alu_src_b = ASB_B;
    bus.alu_op    = ALU_ADD;
    bus.reg_dst   = 1'b0;
    bus.reg_write = 1'b0;
    bus.epc_write = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.ir_write  = 1'b1;
        bus.alu_src_b = ASB_FOUR;
        bus.pc_write  = 1'b1;
      end
      ST_DEC: bus.alu_src_b = ASB_IMM_SL2;
      ST_EXR: begin
        bus.alu_src_a = ASA_A;
        bus.alu_op    = ALU_FUNCT;
      end
      ST_WBR: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      ST_EXI: begin
        bus.alu_src_a = ASA_A;
        bus.alu_src_b = ASB_IMM;
      end
      ST_WBI: bus.reg_write = 1'b1;
      ST_BRAN: begin
        bus.alu_src_a = ASA_A;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = PCS_ALUOUT;
        bus.pc_write  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
      end
      ST_JMP: begin
        bus.pc_src   = PCS_JUMP;
        bus.pc_write = 1'b1;
      end
      ST_JR: begin
        bus.alu_src_a = ASA_A;
        bus.pc_write  = 1'b1;
      end
      ST_RTE: begin
        bus.pc_src   = PCS_EPC;
        bus.pc_write = 1'b1;
      end
      ST_EXC_SAVE: begin
        bus.alu_src_b = ASB_FOUR;
        bus.alu_op    = ALU_SUB;
        bus.epc_write = 1'b1;
      end
      ST_EXC_VEC: begin
        bus.alu_src_a = ASA_ZERO;
        bus.alu_src_b = ASB_VEC;
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cause      = cause_q;
  assign bus.exc_vector = cause_q ? OVF_VEC : OPC_VEC;
  assign bus.state_dbg  = state;

  always_comb begin
    assert (!(bus.pc_write && bus.epc_write));
    if (!reset && (state == ST_EXC_SAVE || state == ST_EXC_VEC))
      assert (cause_valid);
  end

endmodule

// File: tb/tb_pc_ctrl_fsm.sv
// Random-instruction bench for pc_ctrl_fsm: an instruction-level model expands
// each instruction into its expected per-cycle outputs, checked by a monitor.
module tb_pc_ctrl_fsm;
  import mips_ctrl_pkg::*;

  localparam logic [31:0] OPC_V = 32'h0000_0080;
  localparam logic [31:0] OVF_V = 32'h0000_0084;

  typedef struct packed {
    logic [3:0]  state;
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        iord;
    logic        ir_write;
    logic [1:0]  alu_src_a;
    logic [2:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_dst;
    logic        reg_write;
    logic        epc_write;
    logic [31:0] exc_vector;
    logic        cause;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pc_ctrl_fsm_if bus();

  pc_ctrl_fsm #(.OPC_VEC(OPC_V), .OVF_VEC(OVF_V)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        trace[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        cur_cause = 1'b0;

  function automatic exp_t actual();
    exp_t a;
    a.state      = bus.state_dbg;
    a.pc_src     = bus.pc_src;
    a.pc_write   = bus.pc_write;
    a.iord       = bus.iord;
    a.ir_write   = bus.ir_write;
    a.alu_src_a  = bus.alu_src_a;
    a.alu_src_b  = bus.alu_src_b;
    a.alu_op     = bus.alu_op;
    a.reg_dst    = bus.reg_dst;
    a.reg_write  = bus.reg_write;
    a.epc_write  = bus.epc_write;
    a.exc_vector = bus.exc_vector;
    a.cause      = bus.cause;
    return a;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t got;
    got = actual();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: state got %0d want %0d, outputs got %h want %h",
               name, got.state, exp.state, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) check("cycle", sb.pop_front());
    end
  end

  // All strobes/selects zero; cause-derived fields follow the model's cause
  function automatic exp_t blank(input state_t st);
    exp_t e;
    e            = '0;
    e.state      = st;
    e.cause      = cur_cause;
    e.exc_vector = cur_cause ? OVF_V : OPC_V;
    return e;
  endfunction

  task automatic add_exception(input logic c);
    exp_t e;
    cur_cause   = c;
    e           = blank(ST_EXC_SAVE);
    e.alu_src_b = 3'b001;
    e.alu_op    = 2'b01;
    e.epc_write = 1'b1;
    trace.push_back(e);
    e           = blank(ST_EXC_VEC);
    e.alu_src_a = 2'b10;
    e.alu_src_b = 3'b100;
    e.pc_write  = 1'b1;
    trace.push_back(e);
  endtask

  // Instruction-level reference: z/o are the flags seen in the execute cycle
  task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic o);
    exp_t e;
    trace.delete();
    e           = blank(ST_FETCH);
    e.ir_write  = 1'b1;
    e.alu_src_b = 3'b001;
    e.pc_write  = 1'b1;
    trace.push_back(e);
    e           = blank(ST_DEC);
    e.alu_src_b = 3'b011;
    trace.push_back(e);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      e           = blank(ST_EXR);
      e.alu_src_a = 2'b01;
      e.alu_op    = 2'b10;
      trace.push_back(e);
      if (o && fn != 6'h24) add_exception(1'b1);
      else begin
        e           = blank(ST_WBR);
        e.reg_dst   = 1'b1;
        e.reg_write = 1'b1;
        trace.push_back(e);
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      e           = blank(ST_JR);
      e.alu_src_a = 2'b01;
      e.pc_write  = 1'b1;
      trace.push_back(e);
    end else if (op == 6'h00 && fn == 6'h13) begin
      e          = blank(ST_RTE);
      e.pc_src   = 2'b11;
      e.pc_write = 1'b1;
      trace.push_back(e);
    end else if (op == 6'h08) begin
      e           = blank(ST_EXI);
      e.alu_src_a = 2'b01;
      e.alu_src_b = 3'b010;
      trace.push_back(e);
      if (o) add_exception(1'b1);
      else begin
        e           = blank(ST_WBI);
        e.reg_write = 1'b1;
        trace.push_back(e);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e           = blank(ST_BRAN);
      e.alu_src_a = 2'b01;
      e.alu_op    = 2'b01;
      e.pc_src    = 2'b01;
      e.pc_write  = (op == 6'h04) ? z : !z;
      trace.push_back(e);
    end else if (op == 6'h02) begin
      e          = blank(ST_JMP);
      e.pc_src   = 2'b10;
      e.pc_write = 1'b1;
      trace.push_back(e);
    end else begin
      add_exception(1'b0);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z2, input logic o2);
    exp_t tr[$];
    build_trace(op, fn, z2, o2);
    tr = trace;
    for (int i = 0; i < tr.size(); i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        bus.opcode = op;
        bus.funct  = fn;
      end
      bus.zero     = (i == 2) ? z2 : 1'($urandom);
      bus.overflow = (i == 2) ? o2 : 1'($urandom);
      sb.push_back(tr[i]);
    end
  endtask

  task automatic reset_cycle(input logic release_now);
    @(posedge clk);
    #2;
    if (release_now) reset = 1'b0;
    sb.push_back(blank(ST_RST));
  endtask

  task automatic random_instr();
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned k;
    k  = $urandom_range(0, 11);
    fn = 6'($urandom);
    case (k)
      0: begin op = 6'h00; fn = 6'h20; end
      1: begin op = 6'h00; fn = 6'h22; end
      2: begin op = 6'h00; fn = 6'h24; end
      3: begin op = 6'h00; fn = 6'h08; end
      4: begin op = 6'h00; fn = 6'h13; end
      5: op = 6'h08;
      6: op = 6'h04;
      7: op = 6'h05;
      8: op = 6'h02;
      11: op = 6'h00;
      default: op = 6'($urandom);
    endcase
    run_instr(op, fn, 1'($urandom), ($urandom_range(0, 2) == 0));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  initial begin
    bus.opcode   = '0;
    bus.funct    = '0;
    bus.zero     = 1'b0;
    bus.overflow = 1'b0;
    cur_cause    = 1'b0;
    repeat (3) reset_cycle(1'b0);
    reset_cycle(1'b1);

    run_instr(6'h04, 6'h00, 1'b1, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 1'b1);
    run_instr(6'h00, 6'h24, 1'b0, 1'b1);
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    run_instr(6'h00, 6'h13, 1'b0, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 1'b1);
    run_instr(6'h08, 6'h00, 1'b0, 1'b0);
    run_instr(6'h08, 6'h00, 1'b1, 1'b1);
    run_instr(6'h00, 6'h08, 1'b0, 1'b1);

    for (int n = 0; n < 150; n++) random_instr();

    // Abort in WBR: strobes must fall with reset, before the next edge
    run_instr(6'h00, 6'h22, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    cur_cause = 1'b0;
    #1;
    check("async_reset_in_wbr", blank(ST_RST));
    repeat (2) reset_cycle(1'b0);
    reset_cycle(1'b1);

    for (int n = 0; n < 20; n++) random_instr();

    repeat (2) @(posedge clk);
    #7;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
